// File: rtl/spi_ndn_pkg.sv
// Shared types and constants for the SPI/NDN framer: FSM states, command and
// packet-type encodings, and the header width helper.
package spi_ndn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_RX_HDR,
        ST_RX_PAY,
        ST_TX_HDR,
        ST_TX_PAY,
        ST_DRAIN
    } state_t;

    localparam logic CMD_WRITE     = 1'b0;
    localparam logic CMD_READ      = 1'b1;
    localparam logic TYPE_INTEREST = 1'b0;
    localparam logic TYPE_DATA     = 1'b1;

    function automatic int unsigned hdr_w(input int unsigned len_w, input int unsigned prefix_w);
        return 1 + len_w + prefix_w;
    endfunction

endpackage

// File: rtl/spi_ndn_tx_fifo.sv
// Byte-wide synchronous FIFO with show-ahead read data; pushes when full and
// pops when empty are ignored.
module spi_ndn_tx_fifo
    import spi_ndn_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic       o_full,
    output logic       o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spi_ndn_framer.sv
// SPI mode-0 slave framing NDN headers/payload: write frames from the MCU are
// unpacked to rx_*, read frames return the header and FIFO bytes loaded via tx_*.
module spi_ndn_framer
    import spi_ndn_pkg::*;
#(
    parameter int unsigned PREFIX_W = 64,
    parameter int unsigned LEN_W    = 6,
    parameter int unsigned TX_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk,
    input  logic                mosi,
    input  logic                cs,
    output logic                miso,
    output logic                irq,
    output logic                rx_hdr_valid,
    output logic                rx_type,
    output logic [LEN_W-1:0]    rx_length,
    output logic [PREFIX_W-1:0] rx_prefix,
    output logic                rx_byte_valid,
    output logic [7:0]          rx_byte,
    output logic                rx_abort,
    input  logic                tx_load,
    input  logic                tx_type,
    input  logic [LEN_W-1:0]    tx_length,
    input  logic [PREFIX_W-1:0] tx_prefix,
    output logic                tx_busy,
    input  logic                tx_byte_valid,
    input  logic [7:0]          tx_byte,
    output logic                tx_byte_ready,
    output logic                tx_underrun
);

    localparam int unsigned HDR_W = hdr_w(LEN_W, PREFIX_W);
    localparam int unsigned CW    = $clog2(HDR_W);

    logic [1:0] r_sclk_s, r_mosi_s, r_cs_s;
    logic       r_sclk_d, r_cs_d, r_rise, r_fall, r_cs_fall, r_cs_rise, r_mosi_d;

    state_t              r_state, w_state_nx;
    logic [CW-1:0]       r_bit_cnt;
    logic [LEN_W-1:0]    r_byte_cnt;
    logic [HDR_W-2:0]    r_rx_sh;
    logic [7:0]          r_byte_sh;
    logic [HDR_W-1:0]    r_tx_sh;
    logic [7:0]          r_txb_sh;
    logic                r_tx_type;
    logic [LEN_W-1:0]    r_tx_len;
    logic [PREFIX_W-1:0] r_tx_prefix;
    logic                r_tx_busy, r_underrun, r_miso;
    logic                r_hdr_valid, r_byte_valid, r_abort;
    logic                r_rx_type;
    logic [LEN_W-1:0]    r_rx_length;
    logic [PREFIX_W-1:0] r_rx_prefix;
    logic [7:0]          r_rx_byte;

    logic [HDR_W-1:0] w_hdr;
    logic [LEN_W-1:0] w_hdr_len;
    logic             w_hdr_last, w_bit7, w_rx_last, w_tx_last;
    logic             w_abort, w_hdr_done, w_byte_done, w_tx_done, w_load_byte, w_pop, w_shift_en;
    logic             w_empty, w_full;
    logic [7:0]       w_fifo_data;

    assign w_hdr      = {r_rx_sh, r_mosi_d};
    assign w_hdr_len  = w_hdr[PREFIX_W +: LEN_W];
    assign w_hdr_last = (r_bit_cnt == CW'(HDR_W - 1));
    assign w_bit7     = (r_bit_cnt[2:0] == 3'd7);
    assign w_rx_last  = (r_byte_cnt == r_rx_length - 1'b1);
    assign w_tx_last  = (r_byte_cnt == r_tx_len - 1'b1);

    // Edge pulses are registered so that mosi, sclk and cs events line up one
    // cycle after the second synchroniser stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_s  <= '0;
            r_mosi_s  <= '0;
            r_cs_s    <= '1;
            r_sclk_d  <= 1'b0;
            r_cs_d    <= 1'b1;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_cs_fall <= 1'b0;
            r_cs_rise <= 1'b0;
            r_mosi_d  <= 1'b0;
        end else begin
            r_sclk_s  <= {r_sclk_s[0], sclk};
            r_mosi_s  <= {r_mosi_s[0], mosi};
            r_cs_s    <= {r_cs_s[0], cs};
            r_sclk_d  <= r_sclk_s[1];
            r_cs_d    <= r_cs_s[1];
            r_rise    <= r_sclk_s[1] & ~r_sclk_d;
            r_fall    <= ~r_sclk_s[1] & r_sclk_d;
            r_cs_fall <= ~r_cs_s[1] & r_cs_d;
            r_cs_rise <= r_cs_s[1] & ~r_cs_d;
            r_mosi_d  <= r_mosi_s[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_abort     = 1'b0;
        w_hdr_done  = 1'b0;
        w_byte_done = 1'b0;
        w_tx_done   = 1'b0;
        w_load_byte = 1'b0;
        w_pop       = 1'b0;
        w_shift_en  = 1'b0;
        case (r_state)
            ST_IDLE: if (r_cs_fall) w_state_nx = ST_CMD;
            ST_CMD: begin
                if (r_rise) begin
                    if (r_mosi_d == CMD_WRITE) w_state_nx = ST_RX_HDR;
                    else if (r_tx_busy)        w_state_nx = ST_TX_HDR;
                    else                       w_state_nx = ST_DRAIN;
                end
            end
            ST_RX_HDR: begin
                w_shift_en = r_rise;
                if (r_rise && w_hdr_last) begin
                    w_hdr_done = 1'b1;
                    w_state_nx = (w_hdr_len != '0) ? ST_RX_PAY : ST_DRAIN;
                end
            end
            ST_RX_PAY: begin
                w_shift_en = r_rise;
                if (r_rise && w_bit7) begin
                    w_byte_done = 1'b1;
                    if (w_rx_last) w_state_nx = ST_DRAIN;
                end
            end
            ST_TX_HDR: begin
                w_shift_en = r_fall;
                if (r_fall && w_hdr_last) begin
                    if (r_tx_len == '0) begin
                        w_tx_done  = 1'b1;
                        w_state_nx = ST_DRAIN;
                    end else begin
                        w_state_nx = ST_TX_PAY;
                    end
                end
            end
            ST_TX_PAY: begin
                w_shift_en = r_fall;
                if (r_fall) begin
                    w_load_byte = (r_bit_cnt[2:0] == 3'd0);
                    w_pop       = w_load_byte && !w_empty;
                    if (w_bit7 && w_tx_last) begin
                        w_tx_done  = 1'b1;
                        w_state_nx = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: if (r_cs_rise) w_state_nx = ST_IDLE;
            default:  w_state_nx = ST_IDLE;
        endcase
        if (r_cs_rise && r_state != ST_IDLE && r_state != ST_DRAIN) begin
            w_state_nx  = ST_IDLE;
            w_abort     = 1'b1;
            w_hdr_done  = 1'b0;
            w_byte_done = 1'b0;
            w_tx_done   = 1'b0;
            w_load_byte = 1'b0;
            w_pop       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_rx_sh      <= '0;
            r_byte_sh    <= '0;
            r_tx_sh      <= '0;
            r_txb_sh     <= '0;
            r_tx_type    <= TYPE_INTEREST;
            r_tx_len     <= '0;
            r_tx_prefix  <= '0;
            r_tx_busy    <= 1'b0;
            r_underrun   <= 1'b0;
            r_miso       <= 1'b0;
            r_hdr_valid  <= 1'b0;
            r_byte_valid <= 1'b0;
            r_abort      <= 1'b0;
            r_rx_type    <= TYPE_INTEREST;
            r_rx_length  <= '0;
            r_rx_prefix  <= '0;
            r_rx_byte    <= '0;
        end else begin
            r_hdr_valid  <= w_hdr_done;
            r_byte_valid <= w_byte_done;
            r_abort      <= w_abort;
            if (w_hdr_done) begin
                {r_rx_type, r_rx_length, r_rx_prefix} <= w_hdr;
            end
            if (w_byte_done) begin
                r_rx_byte <= {r_byte_sh[6:0], r_mosi_d};
            end

            if (r_state == ST_CMD) begin
                r_bit_cnt  <= '0;
                r_byte_cnt <= '0;
            end else if (w_shift_en) begin
                if (w_hdr_last && (r_state == ST_RX_HDR || r_state == ST_TX_HDR)) begin
                    r_bit_cnt <= '0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                if (w_bit7 && (r_state == ST_RX_PAY || r_state == ST_TX_PAY)) begin
                    r_byte_cnt <= r_byte_cnt + 1'b1;
                end
            end
            if (r_state == ST_RX_HDR && r_rise) begin
                r_rx_sh <= {r_rx_sh[HDR_W-3:0], r_mosi_d};
            end
            if (r_state == ST_RX_PAY && r_rise) begin
                r_byte_sh <= {r_byte_sh[6:0], r_mosi_d};
            end

            if (tx_load && !r_tx_busy) begin
                r_tx_type   <= tx_type;
                r_tx_len    <= tx_length;
                r_tx_prefix <= tx_prefix;
                r_tx_busy   <= 1'b1;
                r_underrun  <= 1'b0;
            end else if (w_tx_done) begin
                r_tx_busy <= 1'b0;
            end

            if (r_state == ST_CMD && w_state_nx == ST_TX_HDR) begin
                r_tx_sh <= {r_tx_type, r_tx_len, r_tx_prefix};
            end
            if (r_state == ST_TX_HDR && r_fall && !w_abort) begin
                r_miso  <= r_tx_sh[HDR_W-1];
                r_tx_sh <= r_tx_sh << 1;
            end
            if (w_load_byte) begin
                if (!w_empty) begin
                    r_miso   <= w_fifo_data[7];
                    r_txb_sh <= {w_fifo_data[6:0], 1'b0};
                end else begin
                    r_miso     <= 1'b0;
                    r_txb_sh   <= '0;
                    r_underrun <= 1'b1;
                end
            end else if (r_state == ST_TX_PAY && r_fall && !w_abort) begin
                r_miso   <= r_txb_sh[7];
                r_txb_sh <= r_txb_sh << 1;
            end
            if (w_state_nx == ST_IDLE || (r_state == ST_CMD && w_state_nx == ST_DRAIN)) begin
                r_miso <= 1'b0;
            end
        end
    end

    spi_ndn_tx_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (tx_byte_valid),
        .i_data  (tx_byte),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign miso          = r_miso;
    assign irq           = r_tx_busy;
    assign tx_busy       = r_tx_busy;
    assign tx_underrun   = r_underrun;
    assign tx_byte_ready = !w_full;
    assign rx_hdr_valid  = r_hdr_valid;
    assign rx_type       = r_rx_type;
    assign rx_length     = r_rx_length;
    assign rx_prefix     = r_rx_prefix;
    assign rx_byte_valid = r_byte_valid;
    assign rx_byte       = r_rx_byte;
    assign rx_abort      = r_abort;

endmodule

// File: tb/tb_spi_ndn_framer.sv
// Directed bench for spi_ndn_framer: bit-banged SPI master plus negedge monitor
// of the rx_* pulses, checked with immediate assertions.
module tb_spi_ndn_framer;
    import spi_ndn_pkg::*;

    localparam int PREFIX_W = 64;
    localparam int LEN_W    = 6;
    localparam int TX_DEPTH = 16;
    localparam int HDR_W    = 1 + LEN_W + PREFIX_W;
    localparam int H        = 50;

    logic                clk = 1'b0;
    logic                rst, sclk, mosi, cs;
    logic                miso, irq, rx_hdr_valid, rx_type, rx_byte_valid, rx_abort;
    logic [LEN_W-1:0]    rx_length;
    logic [PREFIX_W-1:0] rx_prefix;
    logic [7:0]          rx_byte;
    logic                tx_load, tx_type, tx_busy, tx_byte_valid, tx_byte_ready, tx_underrun;
    logic [LEN_W-1:0]    tx_length;
    logic [PREFIX_W-1:0] tx_prefix;
    logic [7:0]          tx_byte;

    int checks   = 0;
    int failures = 0;
    int hdr_cnt  = 0;
    int byte_cnt = 0;
    int abort_cnt = 0;
    logic                h_type;
    logic [LEN_W-1:0]    h_len;
    logic [PREFIX_W-1:0] h_pfx;
    logic [7:0]          blog [0:127];
    logic [7:0]          wbuf [0:63];
    logic [7:0]          rbuf [0:31];
    logic [HDR_W-1:0]    rhdr;
    logic                miso_any;
    logic [8*12-1:0]     msg;

    spi_ndn_framer #(
        .PREFIX_W (PREFIX_W),
        .LEN_W    (LEN_W),
        .TX_DEPTH (TX_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sclk          (sclk),
        .mosi          (mosi),
        .cs            (cs),
        .miso          (miso),
        .irq           (irq),
        .rx_hdr_valid  (rx_hdr_valid),
        .rx_type       (rx_type),
        .rx_length     (rx_length),
        .rx_prefix     (rx_prefix),
        .rx_byte_valid (rx_byte_valid),
        .rx_byte       (rx_byte),
        .rx_abort      (rx_abort),
        .tx_load       (tx_load),
        .tx_type       (tx_type),
        .tx_length     (tx_length),
        .tx_prefix     (tx_prefix),
        .tx_busy       (tx_busy),
        .tx_byte_valid (tx_byte_valid),
        .tx_byte       (tx_byte),
        .tx_byte_ready (tx_byte_ready),
        .tx_underrun   (tx_underrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_hdr_valid) begin
            hdr_cnt <= hdr_cnt + 1;
            h_type  <= rx_type;
            h_len   <= rx_length;
            h_pfx   <= rx_prefix;
        end
        if (rx_byte_valid) begin
            if (byte_cnt < 128) blog[byte_cnt] <= rx_byte;
            byte_cnt <= byte_cnt + 1;
        end
        if (rx_abort) abort_cnt <= abort_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        #H;
        sclk = 1'b1;
        r = miso;
        #H;
        sclk = 1'b0;
    endtask

    task automatic spi_start;
        cs = 1'b0;
        #20;
    endtask

    task automatic spi_end;
        #H;
        cs = 1'b1;
        #(8*H);
    endtask

    task automatic send_vec(input logic [127:0] v, input int n);
        logic r;
        for (int i = n - 1; i >= 0; i--) spi_bit(v[i], r);
    endtask

    task automatic spi_write(input logic t, input logic [LEN_W-1:0] l,
                             input logic [PREFIX_W-1:0] p, input int nb);
        logic r;
        spi_start();
        spi_bit(1'b0, r);
        send_vec(128'({t, l, p}), HDR_W);
        for (int k = 0; k < nb; k++) send_vec(128'(wbuf[k]), 8);
        spi_end();
    endtask

    task automatic spi_read(input int nb);
        logic r;
        spi_start();
        spi_bit(1'b1, r);
        rhdr = '0;
        for (int i = 0; i < HDR_W; i++) begin
            spi_bit(1'b0, r);
            rhdr = {rhdr[HDR_W-2:0], r};
            miso_any = miso_any | r;
        end
        for (int k = 0; k < nb; k++) begin
            rbuf[k] = 8'h00;
            for (int b = 0; b < 8; b++) begin
                spi_bit(1'b0, r);
                rbuf[k] = {rbuf[k][6:0], r};
                miso_any = miso_any | r;
            end
        end
        spi_end();
    endtask

    task automatic do_load(input logic t, input logic [LEN_W-1:0] l, input logic [PREFIX_W-1:0] p);
        @(negedge clk);
        tx_type   = t;
        tx_length = l;
        tx_prefix = p;
        tx_load   = 1'b1;
        @(negedge clk);
        tx_load   = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        tx_byte_valid = 1'b1;
        tx_byte       = b;
        @(negedge clk);
        tx_byte_valid = 1'b0;
    endtask

    initial begin
        int err, bh, ba, bb;
        msg = "here is data";
        rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs = 1'b1;
        tx_load = 1'b0; tx_type = 1'b0; tx_length = '0; tx_prefix = '0;
        tx_byte_valid = 1'b0; tx_byte = '0; miso_any = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_miso", miso, 0);
        chk("rst_irq", irq, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_ready", tx_byte_ready, 1);
        chk("rst_underrun", tx_underrun, 0);
        chk("rst_len_pfx", {rx_type, rx_length, rx_prefix}, 0);

        for (int k = 0; k < 42; k++) wbuf[k] = 8'(k);
        spi_write(1'b0, 6'b101010, 64'd129, 42);
        chk("w42_hdr_cnt", hdr_cnt, 1);
        chk("w42_type", h_type, 0);
        chk("w42_len", h_len, 42);
        chk("w42_pfx", h_pfx, 129);
        chk("w42_byte_cnt", byte_cnt, 42);
        err = 0;
        for (int k = 0; k < 42; k++) if (blog[k] !== 8'(k)) err++;
        chk("w42_byte_order_errs", err, 0);
        chk("w42_no_abort", abort_cnt, 0);

        spi_write(1'b1, 6'd0, 64'hCAFE, 0);
        chk("w0_hdr_cnt", hdr_cnt, 2);
        chk("w0_len", h_len, 0);
        chk("w0_type", h_type, 1);
        chk("w0_pfx", h_pfx, 64'hCAFE);
        chk("w0_no_bytes", byte_cnt, 42);
        chk("w0_idle", dut.r_state, ST_IDLE);

        @(negedge clk);
        tx_type = 1'b1; tx_length = 6'd12; tx_prefix = 64'd129; tx_load = 1'b1;
        chk("irq_before_load", irq, 0);
        @(negedge clk);
        tx_load = 1'b0;
        chk("irq_after_load", irq, 1);
        chk("busy_after_load", tx_busy, 1);
        for (int k = 0; k < 12; k++) push(msg[8*(11-k) +: 8]);
        chk("irq_held", irq, 1);
        spi_read(12);
        chk("tx1_type", rhdr[HDR_W-1], 1);
        chk("tx1_len", rhdr[PREFIX_W +: LEN_W], 12);
        chk("tx1_pfx", rhdr[PREFIX_W-1:0], 129);
        for (int k = 0; k < 12; k++) chk($sformatf("tx1_byte%0d", k), rbuf[k], msg[8*(11-k) +: 8]);
        chk("tx1_irq_clr", irq, 0);
        chk("tx1_busy_clr", tx_busy, 0);
        chk("tx1_no_underrun", tx_underrun, 0);

        do_load(1'b1, 6'd12, 64'd129);
        for (int k = 0; k < 8; k++) push(msg[8*(11-k) +: 8]);
        spi_read(12);
        chk("ur_hdr", rhdr, {1'b1, 6'd12, 64'd129});
        for (int k = 0; k < 8; k++) chk($sformatf("ur_byte%0d", k), rbuf[k], msg[8*(11-k) +: 8]);
        for (int k = 8; k < 12; k++) chk($sformatf("ur_zero%0d", k), rbuf[k], 8'h00);
        chk("ur_flag", tx_underrun, 1);
        chk("ur_busy_clr", tx_busy, 0);
        do_load(1'b1, 6'd0, 64'd77);
        chk("ur_cleared_by_load", tx_underrun, 0);
        chk("busy_len0", tx_busy, 1);
        do_load(1'b0, 6'd5, 64'd5);
        spi_read(0);
        chk("load_while_busy_ignored", rhdr, {1'b1, 6'd0, 64'd77});
        chk("len0_busy_clr", tx_busy, 0);
        chk("len0_irq_clr", irq, 0);

        bh = hdr_cnt; ba = abort_cnt;
        spi_start();
        begin
            logic r;
            spi_bit(1'b0, r);
        end
        send_vec(128'h2AAA_AAAA, 30);
        spi_end();
        chk("abort_pulse", abort_cnt, ba + 1);
        chk("abort_no_hdr", hdr_cnt, bh);
        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A; wbuf[2] = 8'hC3;
        bb = byte_cnt;
        spi_write(1'b1, 6'd3, 64'hDEAD_BEEF_0123_4567, 3);
        chk("post_abort_hdr_cnt", hdr_cnt, bh + 1);
        chk("post_abort_hdr", {h_type, h_len, h_pfx}, {1'b1, 6'd3, 64'hDEAD_BEEF_0123_4567});
        chk("post_abort_bytes", byte_cnt, bb + 3);
        chk("post_abort_b0", blog[bb], 8'hA5);
        chk("post_abort_b1", blog[bb+1], 8'h5A);
        chk("post_abort_b2", blog[bb+2], 8'hC3);

        miso_any = 1'b0;
        spi_read(2);
        chk("empty_read_miso", miso_any, 0);
        chk("empty_read_irq", irq, 0);
        chk("empty_read_busy", tx_busy, 0);

        chk("fifo_ready_pre", tx_byte_ready, 1);
        for (int k = 0; k < TX_DEPTH + 2; k++) push(8'(k));
        chk("fifo_full_ready", tx_byte_ready, 0);
        chk("fifo_full_count", dut.u_fifo.r_count, TX_DEPTH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
